// File: rtl/lot_occupancy_counter.sv
// Multi-lane two-beam vehicle counter: synchronise and debounce each beam, decode
// direction per lane, merge lane events into one saturating count shown as BCD.
module lot_occupancy_counter #(
    parameter int LANES      = 2,
    parameter int DIGITS     = 3,
    parameter int CAPACITY   = 150,
    parameter int DEB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      beam_a,
    input  logic [LANES-1:0]      beam_b,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  full,
    output logic                  empty,
    output logic [LANES-1:0]      ev_in,
    output logic [LANES-1:0]      ev_out,
    output logic [LANES-1:0]      err,
    output logic                  sat
);

    localparam int MAXV = 10**DIGITS - 1;
    localparam int CW   = $clog2(MAXV + 1);
    localparam int NB   = 2 * LANES;
    localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, BAD} lane_state_t;

    // Beam vector layout: bits [LANES-1:0] are A beams, [NB-1:LANES] are B beams.
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] filt_q, filt_d;
    logic [DW-1:0] deb_cnt_q [NB];
    logic [DW-1:0] deb_cnt_d [NB];

    lane_state_t    state_q [LANES];
    logic [1:0]     ab [LANES];
    logic [LANES-1:0] ev_in_q, ev_out_q, err_q;

    logic [CW-1:0]       count_q, count_d;
    logic                sat_q, sat_d;
    logic [4*DIGITS-1:0] count_bcd_q, count_bcd_d;
    logic                full_q, full_d, empty_q, empty_d;
    logic signed [31:0]  sum;

    function automatic logic [4*DIGITS-1:0] to_bcd(input logic [CW-1:0] v);
        logic [4*DIGITS-1:0] b;
        b = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (b[4*d +: 4] >= 4'd5) b[4*d +: 4] = b[4*d +: 4] + 4'd3;
            end
            b = {b[4*DIGITS-2:0], v[i]};
        end
        return b;
    endfunction

    // Debounce: accept the synced value after DEB_CYCLES consecutive differing samples.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            filt_d[i]    = filt_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) filt_d[i] = sync2_q[i];
                else deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            filt_q  <= '1;
            for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= {beam_b, beam_a};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            for (int i = 0; i < NB; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) ab[i] = {~filt_q[i], ~filt_q[LANES+i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) state_q[i] <= IDLE;
            ev_in_q  <= '0;
            ev_out_q <= '0;
            err_q    <= '0;
        end else begin
            ev_in_q  <= '0;
            ev_out_q <= '0;
            err_q    <= '0;
            for (int i = 0; i < LANES; i++) begin
                case (state_q[i])
                    IDLE: begin
                        if (ab[i] == 2'b10) state_q[i] <= EN1;
                        else if (ab[i] == 2'b01) state_q[i] <= EX1;
                        else if (ab[i] == 2'b11) begin state_q[i] <= BAD; err_q[i] <= 1'b1; end
                    end
                    EN1: begin
                        if (ab[i] == 2'b11) state_q[i] <= EN2;
                        else if (ab[i] == 2'b00) state_q[i] <= IDLE;
                    end
                    EN2: begin
                        if (ab[i] == 2'b01) state_q[i] <= EN3;
                        else if (ab[i] == 2'b10) state_q[i] <= EN1;
                        else if (ab[i] == 2'b00) begin state_q[i] <= BAD; err_q[i] <= 1'b1; end
                    end
                    EN3: begin
                        if (ab[i] == 2'b00) begin state_q[i] <= IDLE; ev_in_q[i] <= 1'b1; end
                        else if (ab[i] == 2'b11) state_q[i] <= EN2;
                        else if (ab[i] == 2'b10) begin state_q[i] <= BAD; err_q[i] <= 1'b1; end
                    end
                    EX1: begin
                        if (ab[i] == 2'b11) state_q[i] <= EX2;
                        else if (ab[i] == 2'b00) state_q[i] <= IDLE;
                    end
                    EX2: begin
                        if (ab[i] == 2'b10) state_q[i] <= EX3;
                        else if (ab[i] == 2'b01) state_q[i] <= EX1;
                        else if (ab[i] == 2'b00) begin state_q[i] <= BAD; err_q[i] <= 1'b1; end
                    end
                    EX3: begin
                        if (ab[i] == 2'b00) begin state_q[i] <= IDLE; ev_out_q[i] <= 1'b1; end
                        else if (ab[i] == 2'b11) state_q[i] <= EX2;
                        else if (ab[i] == 2'b01) begin state_q[i] <= BAD; err_q[i] <= 1'b1; end
                    end
                    BAD: begin
                        if (ab[i] == 2'b00) state_q[i] <= IDLE;
                    end
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

    // All lane pulses merge into one signed step, then clip to the displayable range.
    always_comb begin
        sum     = $signed({22'd0, count_q}) + $countones(ev_in_q) - $countones(ev_out_q);
        sat_d   = 1'b0;
        count_d = count_q;
        if (sum < 0) begin
            count_d = '0;
            sat_d   = 1'b1;
        end else if (sum > MAXV) begin
            count_d = CW'(MAXV);
            sat_d   = 1'b1;
        end else begin
            count_d = CW'(sum);
        end
        count_bcd_d = to_bcd(count_q);
        full_d      = (count_q >= CW'(CAPACITY));
        empty_d     = (count_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            sat_q       <= 1'b0;
            count_bcd_q <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            count_q     <= count_d;
            sat_q       <= sat_d;
            count_bcd_q <= count_bcd_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    assign count_bcd = count_bcd_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign ev_in     = ev_in_q;
    assign ev_out    = ev_out_q;
    assign err       = err_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_lot_occupancy_counter.sv
// Directed bench for lot_occupancy_counter: entries, exits, back-out, bounce,
// simultaneous lanes, illegal sequences, reset mid-sequence and count limits.
module tb_lot_occupancy_counter;

    localparam int LANES = 2;
    localparam int DIGITS = 3;
    localparam int CAPACITY = 150;
    localparam int DEB = 4;
    localparam int HOLD = 10;
    localparam int FAST = 8;

    logic clk, rst;
    logic [LANES-1:0] beam_a, beam_b;
    logic [4*DIGITS-1:0] count_bcd;
    logic full, empty, sat;
    logic [LANES-1:0] ev_in, ev_out, err;

    int n_cmp = 0;
    int n_bad = 0;
    int in0 = 0, in1 = 0, out0 = 0, out1 = 0, err0 = 0, err1 = 0, sat_n = 0, both_n = 0;

    lot_occupancy_counter #(
        .LANES(LANES), .DIGITS(DIGITS), .CAPACITY(CAPACITY), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .beam_a(beam_a), .beam_b(beam_b),
        .count_bcd(count_bcd), .full(full), .empty(empty),
        .ev_in(ev_in), .ev_out(ev_out), .err(err), .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles-high counters for each pulse output.
    always @(negedge clk) begin
        if (!rst) begin
            in0    <= in0 + int'(ev_in[0]);
            in1    <= in1 + int'(ev_in[1]);
            out0   <= out0 + int'(ev_out[0]);
            out1   <= out1 + int'(ev_out[1]);
            err0   <= err0 + int'(err[0]);
            err1   <= err1 + int'(err[1]);
            sat_n  <= sat_n + int'(sat);
            both_n <= both_n + int'(ev_in[0] && ev_out[1]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] bcd_of(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Lane patterns are {a,b} with 1 = blocked.
    task automatic ph(input logic [1:0] l0, input logic [1:0] l1, input int n);
        beam_a = ~{l1[1], l0[1]};
        beam_b = ~{l1[0], l0[0]};
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic enter0();
        ph(2'b10, 2'b00, FAST); ph(2'b11, 2'b00, FAST); ph(2'b01, 2'b00, FAST); ph(2'b00, 2'b00, FAST);
    endtask

    task automatic enter_both();
        ph(2'b10, 2'b10, FAST); ph(2'b11, 2'b11, FAST); ph(2'b01, 2'b01, FAST); ph(2'b00, 2'b00, FAST);
    endtask

    task automatic exit1();
        ph(2'b00, 2'b01, FAST); ph(2'b00, 2'b11, FAST); ph(2'b00, 2'b10, FAST); ph(2'b00, 2'b00, FAST);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        beam_a = '1;
        beam_b = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (count_bcd !== 12'h000) begin n_bad++; $display("FAIL reset_count: got %h want 000", count_bcd); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if ({ev_in, ev_out, err, sat} !== 7'd0) begin n_bad++; $display("FAIL reset_pulses: got %b want 0", {ev_in, ev_out, err, sat}); end
    endtask

    task automatic test_entry();
        bit seen;
        ph(2'b10, 2'b00, HOLD); ph(2'b11, 2'b00, HOLD); ph(2'b01, 2'b00, HOLD);
        beam_a = '1;
        beam_b = '1;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (ev_in[0]) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL entry_pulse: got no ev_in[0] want pulse"); end
        n_cmp++; if (count_bcd !== 12'h000) begin n_bad++; $display("FAIL entry_lat0: got %h want 000", count_bcd); end
        @(negedge clk);
        n_cmp++; if (count_bcd !== 12'h000) begin n_bad++; $display("FAIL entry_lat1: got %h want 000", count_bcd); end
        @(negedge clk);
        n_cmp++; if (count_bcd !== 12'h001) begin n_bad++; $display("FAIL entry_lat2: got %h want 001", count_bcd); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL entry_empty: got %b want 0", empty); end
        settle();
        n_cmp++; if (in0 !== 1) begin n_bad++; $display("FAIL entry_width: got %0d want 1", in0); end
    endtask

    task automatic test_exit_backout();
        int in0_s, out1_s;
        repeat (4) enter0();
        settle();
        n_cmp++; if (count_bcd !== bcd_of(5)) begin n_bad++; $display("FAIL count_five: got %h want 005", count_bcd); end
        out1_s = out1;
        exit1();
        settle();
        n_cmp++; if (count_bcd !== bcd_of(4)) begin n_bad++; $display("FAIL exit_count: got %h want 004", count_bcd); end
        n_cmp++; if (out1 - out1_s !== 1) begin n_bad++; $display("FAIL exit_pulse: got %0d want 1", out1 - out1_s); end
        in0_s = in0;
        ph(2'b10, 2'b00, FAST); ph(2'b11, 2'b00, FAST); ph(2'b10, 2'b00, FAST); ph(2'b00, 2'b00, FAST);
        settle();
        n_cmp++; if (count_bcd !== bcd_of(4)) begin n_bad++; $display("FAIL backout_count: got %h want 004", count_bcd); end
        n_cmp++; if (in0 - in0_s !== 0 || err0 !== 0) begin n_bad++; $display("FAIL backout_events: got in %0d err %0d want 0 0", in0 - in0_s, err0); end
    endtask

    task automatic test_bounce();
        int in0_s, out0_s, err0_s;
        in0_s = in0; out0_s = out0; err0_s = err0;
        beam_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        beam_a[0] = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        n_cmp++; if (dut.filt_q[0] !== 1'b1) begin n_bad++; $display("FAIL bounce_filt: got %b want 1", dut.filt_q[0]); end
        n_cmp++; if ({in0 - in0_s, out0 - out0_s, err0 - err0_s} !== {32'd0, 32'd0, 32'd0}) begin
            n_bad++; $display("FAIL bounce_pulses: got %0d %0d %0d want 0 0 0", in0 - in0_s, out0 - out0_s, err0 - err0_s);
        end
        n_cmp++; if (count_bcd !== bcd_of(4)) begin n_bad++; $display("FAIL bounce_count: got %h want 004", count_bcd); end
    endtask

    task automatic test_simultaneous();
        int both_s, sat_s;
        enter_both();
        enter0();
        settle();
        n_cmp++; if (count_bcd !== bcd_of(7)) begin n_bad++; $display("FAIL count_seven: got %h want 007", count_bcd); end
        both_s = both_n; sat_s = sat_n;
        ph(2'b10, 2'b01, FAST); ph(2'b11, 2'b11, FAST); ph(2'b01, 2'b10, FAST); ph(2'b00, 2'b00, FAST);
        settle();
        n_cmp++; if (both_n - both_s !== 1) begin n_bad++; $display("FAIL simul_pulses: got %0d want 1", both_n - both_s); end
        n_cmp++; if (count_bcd !== bcd_of(7)) begin n_bad++; $display("FAIL simul_count: got %h want 007", count_bcd); end
        n_cmp++; if (sat_n - sat_s !== 0) begin n_bad++; $display("FAIL simul_sat: got %0d want 0", sat_n - sat_s); end
    endtask

    task automatic test_illegal();
        int err0_s, in0_s, in1_s;
        err0_s = err0; in0_s = in0; in1_s = in1;
        ph(2'b11, 2'b00, HOLD);
        n_cmp++; if (err0 - err0_s !== 1) begin n_bad++; $display("FAIL illegal_err: got %0d want 1", err0 - err0_s); end
        ph(2'b11, 2'b10, FAST); ph(2'b11, 2'b11, FAST); ph(2'b11, 2'b01, FAST); ph(2'b11, 2'b00, FAST);
        ph(2'b00, 2'b00, FAST);
        settle();
        n_cmp++; if (count_bcd !== bcd_of(8)) begin n_bad++; $display("FAIL illegal_count: got %h want 008", count_bcd); end
        n_cmp++; if (in1 - in1_s !== 1 || in0 - in0_s !== 0) begin n_bad++; $display("FAIL illegal_lanes: got in1 %0d in0 %0d want 1 0", in1 - in1_s, in0 - in0_s); end
        n_cmp++; if (err0 - err0_s !== 1) begin n_bad++; $display("FAIL illegal_errwidth: got %0d want 1", err0 - err0_s); end
    endtask

    task automatic test_reset_mid();
        int err0_s;
        repeat (2) enter_both();
        settle();
        n_cmp++; if (count_bcd !== bcd_of(12)) begin n_bad++; $display("FAIL count_twelve: got %h want 012", count_bcd); end
        ph(2'b10, 2'b00, HOLD); ph(2'b11, 2'b00, HOLD);
        err0_s = err0;
        rst = 1'b1;
        beam_a = '1;
        beam_b = '1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (count_bcd !== 12'h000 || empty !== 1'b1) begin n_bad++; $display("FAIL rst_mid: got %h empty %b want 000 empty 1", count_bcd, empty); end
        n_cmp++; if (dut.state_q[0] !== dut.IDLE) begin n_bad++; $display("FAIL rst_fsm: got %0d want IDLE", dut.state_q[0]); end
        repeat (15) @(negedge clk);
        #1;
        n_cmp++; if (err0 - err0_s !== 0) begin n_bad++; $display("FAIL rst_err: got %0d want 0", err0 - err0_s); end
        enter0();
        settle();
        n_cmp++; if (count_bcd !== bcd_of(1)) begin n_bad++; $display("FAIL rst_then_entry: got %h want 001", count_bcd); end
    endtask

    task automatic test_limits();
        int sat_s, in0_s;
        exit1();
        settle();
        n_cmp++; if (count_bcd !== 12'h000 || empty !== 1'b1) begin n_bad++; $display("FAIL to_zero: got %h empty %b want 000 1", count_bcd, empty); end
        sat_s = sat_n;
        exit1();
        settle();
        n_cmp++; if (count_bcd !== 12'h000) begin n_bad++; $display("FAIL under_count: got %h want 000", count_bcd); end
        n_cmp++; if (sat_n - sat_s !== 1) begin n_bad++; $display("FAIL under_sat: got %0d want 1", sat_n - sat_s); end
        repeat (74) enter_both();
        enter0();
        settle();
        n_cmp++; if (count_bcd !== 12'h149 || full !== 1'b0) begin n_bad++; $display("FAIL at_149: got %h full %b want 149 0", count_bcd, full); end
        enter0();
        settle();
        n_cmp++; if (count_bcd !== 12'h150 || full !== 1'b1) begin n_bad++; $display("FAIL at_150: got %h full %b want 150 1", count_bcd, full); end
        repeat (424) enter_both();
        settle();
        n_cmp++; if (count_bcd !== 12'h998 || full !== 1'b1) begin n_bad++; $display("FAIL at_998: got %h full %b want 998 1", count_bcd, full); end
        sat_s = sat_n;
        enter0();
        settle();
        n_cmp++; if (count_bcd !== 12'h999 || sat_n - sat_s !== 0) begin n_bad++; $display("FAIL at_999: got %h sat %0d want 999 0", count_bcd, sat_n - sat_s); end
        in0_s = in0;
        enter0();
        settle();
        n_cmp++; if (count_bcd !== 12'h999) begin n_bad++; $display("FAIL over_count: got %h want 999", count_bcd); end
        n_cmp++; if (sat_n - sat_s !== 1 || in0 - in0_s !== 1) begin n_bad++; $display("FAIL over_sat: got sat %0d in %0d want 1 1", sat_n - sat_s, in0 - in0_s); end
    endtask

    initial begin
        rst = 1'b1;
        beam_a = '1;
        beam_b = '1;
        @(negedge clk);
        test_reset();
        test_entry();
        test_exit_backout();
        test_bounce();
        test_simultaneous();
        test_illegal();
        test_reset_mid();
        test_limits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
